// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents: FSM state encoding, datapath/counter widths and the quotient
// returned on a divide-by-zero.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_CNT_W = 5;

  localparam logic [DIV_W-1:0] ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : div_pkg

// File: rtl/div_csa32.sv
// One restoring-division step: conditional subtract of B from A.
// Ports:
//   A_i    in  32 : shifted partial remainder
//   B_i    in  32 : divisor
//   Q_o    out 32 : A-B when no borrow, otherwise A unchanged
//   Bo31_o out 1  : borrow out of bit 31 (1 means A < B)
// The subtract is built as four byte slices with a rippled borrow.
module div_csa32
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] A_i,
  input  logic [DIV_W-1:0] B_i,
  output logic [DIV_W-1:0] Q_o,
  output logic             Bo31_o
);

  logic [4:0]       borrow;
  logic [DIV_W-1:0] sub;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_slice
    logic [8:0] diff;
    // The 9th bit of the widened difference is set exactly when the byte
    // result went negative, i.e. it is the borrow into the next slice.
    assign diff          = {1'b0, A_i[8*i +: 8]} - {1'b0, B_i[8*i +: 8]}
                         - {8'd0, borrow[i]};
    assign sub[8*i +: 8] = diff[7:0];
    assign borrow[i+1]   = diff[8];
  end

  assign Bo31_o = borrow[4];
  assign Q_o    = borrow[4] ? A_i : sub;

endmodule : div_csa32

// File: rtl/div_seq32.sv
// Sequential unsigned 32/32 restoring divider, one quotient bit per clock.
// Ports:
//   clk_i          in  1  : clock, rising edge
//   rst_i          in  1  : asynchronous active-high reset
//   in_valid_i     in  1  : operands valid
//   in_ready_o     out 1  : block idle and able to accept operands
//   dividend_i     in  32 : dividend N
//   divisor_i      in  32 : divisor D
//   out_valid_o    out 1  : result valid, held until out_ready_i
//   out_ready_i    in  1  : consumer accepts result
//   quotient_o     out 32 : floor(N/D), ZERO_QUOT when D == 0
//   remainder_o    out 32 : N mod D, N when D == 0
//   div_by_zero_o  out 1  : result came from D == 0
// All outputs decode from registered state only; out_ready_i only
// affects the next state.
module div_seq32
  import div_pkg::*;
#(
  parameter logic [DIV_W-1:0] ZERO_QUOT_P = ZERO_QUOT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DIV_W-1:0] quotient_o,
  output logic [DIV_W-1:0] remainder_o,
  output logic             div_by_zero_o
);

  div_state_t           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]     q_q, q_d;
  logic [DIV_W-1:0]     r_q, r_d;
  logic [DIV_W-1:0]     d_q, d_d;
  logic                 dbz_q, dbz_d;

  logic [DIV_W-1:0]     step_a;
  logic [DIV_W-1:0]     step_r;
  logic                 step_borrow;

  // The partial remainder is always below D, so R[31] is zero before the
  // shift and dropping it loses nothing; no 33rd bit is required.
  assign step_a = {r_q[DIV_W-2:0], q_q[DIV_W-1]};

  div_csa32 u_step (
    .A_i    (step_a),
    .B_i    (d_q),
    .Q_o    (step_r),
    .Bo31_o (step_borrow)
  );

  // NOTE: every signal gets its hold value before the case statement so
  // that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          d_d   = divisor_i;
          cnt_d = DIV_CNT_W'(DIV_W - 1);
          if (divisor_i == '0) begin
            q_d     = ZERO_QUOT_P;
            r_d     = dividend_i;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = dividend_i;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        q_d   = {q_q[DIV_W-2:0], ~step_borrow};
        r_d   = step_r;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready_o    = (state_q == IDLE);
  assign out_valid_o   = (state_q == DONE);
  assign quotient_o    = q_q;
  assign remainder_o   = r_q;
  assign div_by_zero_o = dbz_q;

endmodule : div_seq32

// File: tb/tb_div_seq32.sv
// Directed bench for div_seq32: latency, results, divide-by-zero,
// backpressure, mid-operation reset and ignored operands while busy.
module tb_div_seq32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_by_zero_o;

  int n_vec = 0;
  int n_err = 0;

  div_seq32 dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One complete operation. hold = cycles the result is held off with
  // out_ready_i low; junk = drive random operands with in_valid_i while busy.
  task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input logic exp_z, input int hold, input logic junk);
    int lat;
    int t;
    logic [31:0] exp_lat;
    exp_lat = (d == 0) ? 32'd1 : 32'd33;
    t = 0;
    while (!in_ready_o && t < 100) begin tick(); t++; end
    check("in_ready_before", {31'd0, in_ready_o}, 32'd1);
    out_ready_i = (hold == 0);
    in_valid_i  = 1'b1;
    dividend_i  = n;
    divisor_i   = d;
    tick();
    in_valid_i = 1'b0;
    lat = 1;
    check("in_ready_busy", {31'd0, in_ready_o}, 32'd0);
    if (junk) begin
      in_valid_i = 1'b1;
      dividend_i = $urandom;
      divisor_i  = $urandom;
    end
    while (!out_valid_o && lat < 64) begin tick(); lat++; end
    in_valid_i = 1'b0;
    check("latency", 32'(lat), exp_lat);
    check("out_valid", {31'd0, out_valid_o}, 32'd1);
    check("quotient", quotient_o, exp_q);
    check("remainder", remainder_o, exp_r);
    check("div_by_zero", {31'd0, div_by_zero_o}, {31'd0, exp_z});
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {31'd0, out_valid_o}, 32'd1);
      check("hold_quotient", quotient_o, exp_q);
      check("hold_remainder", remainder_o, exp_r);
      check("hold_in_ready", {31'd0, in_ready_o}, 32'd0);
    end
    out_ready_i = 1'b1;
    tick();
    check("idle_after_hs", {30'd0, in_ready_o, out_valid_o}, 32'b10);
  endtask

  initial begin
    logic [31:0] rn, rd, rq, rr;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    dividend_i  = '0;
    divisor_i   = '0;
    #12;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_quotient", quotient_o, 32'd0);
    check("rst_remainder", remainder_o, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 0, 1'b0);
    run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 1'b0);
    run_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 10, 1'b0);
    run_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 0, 1'b1);
    run_op(32'h1234, 32'h1234, 32'd1, 32'd0, 1'b0, 0, 1'b1);
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 1'b0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 1'b0);
    run_op(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 2, 1'b0);

    // Reset in the middle of a calculation.
    in_valid_i = 1'b1;
    dividend_i = 32'd12345;
    divisor_i  = 32'd67;
    tick();
    in_valid_i = 1'b0;
    repeat (15) tick();
    rst_i = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("midrst_quotient", quotient_o, 32'd0);
    check("midrst_remainder", remainder_o, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
    run_op(32'd12345, 32'd67, 32'd184, 32'd17, 1'b0, 0, 1'b0);

    // Short random regression with busy-time operand noise.
    for (int k = 0; k < 100; k++) begin
      rn = $urandom;
      case (k % 4)
        0: rd = $urandom;
        1: rd = $urandom_range(1, 1000);
        2: rd = rn;
        default: rd = 32'hFFFF_FFFF;
      endcase
      if (rd == 0) begin
        rq = 32'hFFFF_FFFF;
        rr = rn;
      end else begin
        rq = rn / rd;
        rr = rn % rd;
      end
      run_op(rn, rd, rq, rr, rd == 0, k % 3, k[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_div_seq32
